// File: rtl/spi_sample_buffer.sv
// spi_sample_buffer
//   First-word-fall-through buffer for words coming out of an SPI RX shift
//   register. A word is captured on the rising edge of Data_Ready. The head
//   word is presented on Sample_Data/Sample_Valid and is consumed with
//   Sample_Ready. If a capture arrives while the buffer is full and no word
//   leaves in the same cycle, the new word is dropped and the sticky Overflow
//   flag is set.
//
//   Optional feature macro: SAMPLE_TIMESTAMP_EN
//     When defined, a free-running 16-bit cycle counter is stored with each
//     captured word and presented on Sample_Timestamp, aligned with
//     Sample_Data.
//
//   Ports
//     clk              in   rising-edge clock
//     reset_b          in   asynchronous active-low reset
//     RX_Data          in   [DATA_WIDTH] word from the SPI RX shift register
//     Data_Ready       in   word-complete strobe (edge detected)
//     Sample_Data      out  [DATA_WIDTH] head-of-buffer word (0 when empty)
//     Sample_Valid     out  Sample_Data holds a valid word
//     Sample_Ready     in   consumer accepts the head word
//     Fill_Level       out  [log2(DEPTH)+1] number of stored words
//     Overflow         out  sticky dropped-word flag
//     Overflow_Clear   in   synchronous clear of Overflow
//     Sample_Timestamp out  [16] capture-cycle count of the head word
//                           (only with SAMPLE_TIMESTAMP_EN)
module spi_sample_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [DATA_WIDTH-1:0]   RX_Data,
    input  logic                    Data_Ready,
    output logic [DATA_WIDTH-1:0]   Sample_Data,
    output logic                    Sample_Valid,
    input  logic                    Sample_Ready,
    output logic [$clog2(DEPTH):0]  Fill_Level,
    output logic                    Overflow,
    input  logic                    Overflow_Clear
`ifdef SAMPLE_TIMESTAMP_EN
    ,
    output logic [15:0]             Sample_Timestamp
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_sample_buffer: DEPTH must be a power of two and at least 2");
    end

    // Control state
    logic          dr_prev_q, dr_prev_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          overflow_q, overflow_d;

    // Word storage (not reset; validity is tracked by fill_q)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic capture;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;
    logic valid;

    always_comb begin
        valid   = (fill_q != '0);
        full    = (fill_q == FW'(DEPTH));
        capture = Data_Ready & ~dr_prev_q;
        pop     = valid & Sample_Ready;
        // A full buffer still accepts a word when the head leaves the same
        // cycle: the slot being written is the one being vacated.
        wr_en   = capture & (~full | pop);
        drop    = capture & full & ~pop;
    end

    always_comb begin
        dr_prev_d  = Data_Ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            fill_d = fill_q + FW'(1);
        end else if (pop && !wr_en) begin
            fill_d = fill_q - FW'(1);
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (Overflow_Clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dr_prev_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            dr_prev_q  <= dr_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= RX_Data;
        end
    end

    // Head word is read straight from storage; gating with valid forces zero
    // while empty or in reset, since storage itself is never cleared.
    assign Sample_Valid = valid;
    assign Sample_Data  = valid ? mem_q[rd_ptr_q] : '0;
    assign Fill_Level   = fill_q;
    assign Overflow     = overflow_q;

`ifdef SAMPLE_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_mem_q [DEPTH];

    always_comb begin
        ts_cnt_d = ts_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ts_cnt_q <= 16'd0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end

    // The stored stamp is the counter value during the capture cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ts_mem_q[wr_ptr_q] <= ts_cnt_q;
        end
    end

    assign Sample_Timestamp = valid ? ts_mem_q[rd_ptr_q] : 16'd0;
`endif

endmodule

// File: doc/spi_sample_buffer.md
SPI_SAMPLE_BUFFER -- requirements
Module: SPI_SAMPLE_BUFFER

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one SPI RX sample word.
REQ-002 Parameter DEPTH, default 16: buffer entries; SHALL be a power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_b, input, 1: reset, asynchronous and active-low.
REQ-005 Port RX_Data, input, DATA_WIDTH: parallel word from the SPI RX shift register.
REQ-006 Port Data_Ready, input, 1: word-complete strobe from the SPI controller.
REQ-007 Port Sample_Data, output, DATA_WIDTH: head-of-buffer word.
REQ-008 Port Sample_Valid, output, 1: Sample_Data holds a valid word.
REQ-009 Port Sample_Ready, input, 1: consumer accepts the head word.
REQ-010 Port Fill_Level, output, log2(DEPTH)+1: number of stored words.
REQ-011 Port Overflow, output, 1: sticky flag, set when a word was dropped.
REQ-012 Port Overflow_Clear, input, 1: synchronous clear of Overflow.

Function
REQ-013 Capture SHALL occur on the cycle where Data_Ready=1 and the registered previous Data_Ready=0 (rising edge only); RX_Data is sampled that cycle.
REQ-014 Data_Ready held high for several cycles SHALL produce exactly one capture.
REQ-015 Pop SHALL occur on the cycle where Sample_Valid=1 and Sample_Ready=1.
REQ-016 Buffer SHALL be first-word-fall-through: a word captured into an empty buffer SHALL appear on Sample_Data with Sample_Valid=1 on the next cycle, with no combinational pass-through.
REQ-017 Sample_Data SHALL remain stable while Sample_Valid=1 and Sample_Ready=0.
REQ-018 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 Fill_Level SHALL be +1 on capture only, -1 on pop only, and unchanged on a simultaneous capture and pop.
REQ-020 Full is Fill_Level==DEPTH. A capture while full without a same-cycle pop SHALL be dropped, leave pointers and data unchanged, and set Overflow=1 on the next cycle.
REQ-021 A capture while full with a same-cycle pop SHALL be accepted, with no overflow.
REQ-022 With Fill_Level==0, Sample_Valid SHALL be 0, and Sample_Ready SHALL be ignored.
REQ-023 If Overflow_Clear and a dropped capture occur in the same cycle, Overflow SHALL be 1 (set wins).
REQ-024 Word order SHALL be strictly preserved; no word is duplicated.

Reset
REQ-025 While reset_b=0: Sample_Valid=0, Fill_Level=0, Overflow=0, Sample_Data=0, pointers=0, previous-Data_Ready register=0; storage contents need not be cleared.
REQ-026 Reset asserted mid-transfer SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-027 A Data_Ready already high at the first clock after reset release SHALL count as a rising edge and be captured.

Configuration
REQ-028 With macro SAMPLE_TIMESTAMP_EN defined: a free-running 16-bit counter (reset 0, wrapping 65535->0) SHALL be stored with each captured word; output Sample_Timestamp[15:0] SHALL carry the value counted on that word's capture cycle, aligned with Sample_Data.
REQ-029 Without SAMPLE_TIMESTAMP_EN: no counter, no timestamp storage, and no Sample_Timestamp port; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then Data_Ready pulse with RX_Data=16'hA5A5 and Sample_Ready=0 -> next cycle Sample_Valid=1, Sample_Data=A5A5, Fill_Level=1.
REQ-031 Data_Ready held high for 5 cycles with RX_Data=16'h1234 -> exactly one word stored, Fill_Level=1.
REQ-032 16 pulses with data 0..15 and Sample_Ready=0, then a 17th pulse with 16'hFFFF -> Fill_Level=16, Overflow=1; draining yields 0..15 and no FFFF.
REQ-033 Full buffer, capture of 16'h0BEE in the same cycle as a pop -> Overflow stays 0, Fill_Level stays 16, and 0BEE is read last.
REQ-034 Pointer wrap: 40 words streamed with Sample_Ready=1 -> all 40 words read in order, Fill_Level never above 1.
REQ-035 reset_b pulsed low with Fill_Level=7 -> Sample_Valid=0 and Fill_Level=0 immediately; with SAMPLE_TIMESTAMP_EN, captures 3 cycles apart give timestamps differing by 3.
